// File: rtl/conv_row_serializer.sv
// conv_row_serializer
// Takes one full convolution output row per handshake (ROW_LEN parallel
// pixels) and re-emits it as a raster pixel stream, one pixel per clock.
// Two row slots in ping-pong let the producer refill one slot while the
// other drains. Row/frame markers come from the read-side column and row
// counters.

module conv_row_serializer #(
   parameter int ROW_LEN  = 24,
   parameter int ROWS     = 24,
   parameter int DATA_BIT = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ROW_LEN*DATA_BIT-1:0]  in_row,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_BIT-1:0]          out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_eol,
   output logic                         out_eof
);

   localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   typedef logic [DATA_BIT-1:0] pixel_t;

   // Row storage: slot index is the ping-pong pointer, second index the column.
   pixel_t           slot_q [2][ROW_LEN];

   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   logic             accept;
   logic             xfer;
   logic             row_done;

   // All outputs decode registered state only; no input reaches an output
   // combinationally, so this block can sit between two timing-closed stages.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_eol   = out_valid & (col_q == COL_LAST);
   assign out_eof   = out_eol & (row_q == ROW_LAST);
   assign out_data  = out_valid ? slot_q[rd_ptr_q][col_q] : '0;

   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   assign row_done  = xfer & (col_q == COL_LAST);

   // Next-state logic for pointers, occupancy and the raster position.
   // NOTE: every signal gets a default at the top so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      col_d    = col_q;
      row_d    = row_q;

      if (accept) begin
         wr_ptr_d = ~wr_ptr_q;
      end

      if (xfer) begin
         col_d = row_done ? '0 : col_q + 1'b1;
      end

      if (row_done) begin
         rd_ptr_d = ~rd_ptr_q;
         row_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end

      // Accept and release in the same cycle cancel out; the pointers
      // still both advance above.
      case ({accept, row_done})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

   // Capture an accepted row into the write slot.
   // NOTE: the slot array is deliberately not reset; its contents are only
   // observable after a row has been written, and out_data is forced to 0
   // while the buffer is empty.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < ROW_LEN; k++) begin
            slot_q[wr_ptr_q][k] <= in_row[k*DATA_BIT +: DATA_BIT];
         end
      end
   end

endmodule
